// File: rtl/sm4_block_feeder_pkg.sv
// rtl/sm4_block_feeder_pkg.sv - widths, types and pack-state enum shared by the SM4 block feeder
package sm4_encryptor;
  localparam int group_size_p       = 128;
  localparam int word_width_p       = 32;
  localparam int words_per_group_lp = group_size_p / word_width_p;
  localparam int cnt_width_lp       = $clog2(words_per_group_lp);

  typedef logic [group_size_p-1:0] sm4_group_t;
  typedef logic [word_width_p-1:0] sm4_word_t;
  typedef logic [cnt_width_lp-1:0] sm4_cnt_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} feeder_pack_state_e;
endpackage

// File: rtl/sm4_block_feeder_packer.sv
// rtl/sm4_block_feeder_packer.sv - word counter plus shift register packing words into one group
// group_o is the group as it would look with word_i shifted in, so a completing word can bypass the register.
module sm4_word_packer
  import sm4_encryptor::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       accept_i,
  input  sm4_word_t  word_i,
  output logic       first_o,
  output logic       done_o,
  output sm4_group_t shift_o,
  output sm4_group_t group_o
);
  localparam sm4_cnt_t last_lp = sm4_cnt_t'(words_per_group_lp - 1);

  sm4_cnt_t   cnt_q, cnt_d;
  sm4_group_t shift_q, shift_d;

  assign first_o = (cnt_q == '0);
  assign done_o  = accept_i & (cnt_q == last_lp);
  assign shift_o = shift_q;
  assign group_o = {shift_q[group_size_p-word_width_p-1:0], word_i};

  // clear only rewinds the counter; a completed group left in shift_q stays intact
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept_i) begin
      shift_d = group_o;
      cnt_d   = (cnt_q == last_lp) ? '0 : sm4_cnt_t'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/sm4_block_feeder.sv
// rtl/sm4_block_feeder.sv - packs 32-bit words into 128-bit groups for the SM4 encryptor input
// Optional SM4_FEEDER_KEY_STREAM_EN: key arrives as tagged words on the data stream instead of key_i.
module sm4_block_feeder
  import sm4_encryptor::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  sm4_word_t  word_i,
  input  logic       word_v_i,
  output logic       word_ready_o,
  input  logic       mode_i,
  input  logic       flush_i,
`ifdef SM4_FEEDER_KEY_STREAM_EN
  input  logic       word_key_i,
`else
  input  sm4_group_t key_i,
`endif
  output sm4_group_t content_o,
  output sm4_group_t key_o,
  output logic       encode_or_decode_o,
  output logic       v_o,
  input  logic       ready_i
);
  feeder_pack_state_e state_q, state_d;
  logic       mode_q, mode_d;
  sm4_group_t pend_key_q, pend_key_d;
  sm4_group_t content_q, content_d;
  sm4_group_t key_q, key_d;
  logic       eod_q, eod_d;
  logic       v_q, v_d;

  logic       word_fire, data_fire, data_first, data_done;
  logic       out_free, load_full, load_new, group_mode;
  sm4_group_t data_shift, data_group, group_key;

  assign word_ready_o = (state_q != FULL) & ~flush_i;
  assign word_fire    = word_v_i & word_ready_o;

`ifdef SM4_FEEDER_KEY_STREAM_EN
  logic       key_done, key_first;
  sm4_group_t key_group, key_shift, key_reg_q;
  logic       unused_key_ok;

  assign data_fire     = word_fire & ~word_key_i;
  assign unused_key_ok = key_first ^ (^key_shift);

  sm4_word_packer u_key_packer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (flush_i),
    .accept_i (word_fire & word_key_i),
    .word_i   (word_i),
    .first_o  (key_first),
    .done_o   (key_done),
    .shift_o  (key_shift),
    .group_o  (key_group)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)      key_reg_q <= '0;
    else if (key_done) key_reg_q <= key_group;
  end

  // a key completing alongside a data group is the one that group carries
  assign group_key = key_done ? key_group : key_reg_q;
`else
  assign data_fire = word_fire;
  assign group_key = key_i;
`endif

  sm4_word_packer u_data_packer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (flush_i),
    .accept_i (data_fire),
    .word_i   (word_i),
    .first_o  (data_first),
    .done_o   (data_done),
    .shift_o  (data_shift),
    .group_o  (data_group)
  );

  assign group_mode = (data_fire & data_first) ? mode_i : mode_q;
  assign out_free   = ~v_q | ready_i;
  assign load_full  = (state_q == FULL) & out_free;
  assign load_new   = data_done & out_free;

  always_comb begin
    state_d    = state_q;
    pend_key_d = pend_key_q;
    mode_d     = group_mode;
    v_d        = v_q & ~ready_i;
    content_d  = content_q;
    key_d      = key_q;
    eod_d      = eod_q;
    if (load_full) begin
      state_d = EMPTY;
    end else if (data_done) begin
      state_d = out_free ? EMPTY : FULL;
      if (!out_free) pend_key_d = group_key;
    end else if (flush_i && state_q != FULL) begin
      state_d = EMPTY;
    end else if (data_fire) begin
      state_d = FILLING;
    end
    // FULL never coexists with a completing word, so the two loads are exclusive
    if (load_full) begin
      v_d       = 1'b1;
      content_d = data_shift;
      key_d     = pend_key_q;
      eod_d     = mode_q;
    end else if (load_new) begin
      v_d       = 1'b1;
      content_d = data_group;
      key_d     = group_key;
      eod_d     = group_mode;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= EMPTY;
      mode_q     <= 1'b0;
      pend_key_q <= '0;
      v_q        <= 1'b0;
      content_q  <= '0;
      key_q      <= '0;
      eod_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pend_key_q <= pend_key_d;
      v_q        <= v_d;
      content_q  <= content_d;
      key_q      <= key_d;
      eod_q      <= eod_d;
    end
  end

  assign content_o          = content_q;
  assign key_o              = key_q;
  assign encode_or_decode_o = eod_q;
  assign v_o                = v_q;
endmodule

// File: doc/sm4_block_feeder.md
# sm4_block_feeder

Front-end producer for the SM4 encryptor core. Accepts a 32-bit word stream over a valid/ready handshake and packs four words into one 128-bit group. Attaches the key and the encode/decode mode, then presents the group to the encryptor's `v_i`/`ready_o` input handshake. One group is buffered behind the output register, so packing of the next group overlaps with the encryptor stalling on the current one.

## Interface
Parameters:
- `group_size_p`, 128 (from package): group and key width in bits.
- `word_width_p`, 32: input word width; `group_size_p` must be an exact multiple of it.

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-low.
- `word_i`  in  `word_width_p`  input data word; the first word of a group is the most significant.
- `word_v_i`  in  1  `word_i` valid.
- `word_ready_o`  out  1  word accepted when `word_v_i & word_ready_o`.
- `mode_i`  in  1  encode(0)/decode(1); sampled with the first word of each group.
- `flush_i`  in  1  synchronous abort of a partially packed group.
- `key_i`  in  `group_size_p`  cipher key (only without `SM4_FEEDER_KEY_STREAM_EN`).
- `content_o`  out  `group_size_p`  packed group; drives encryptor `content_i`.
- `key_o`  out  `group_size_p`  key for the presented group.
- `encode_or_decode_o`  out  1  mode for the presented group.
- `v_o`  out  1  group valid; drives encryptor `v_i`.
- `ready_i`  in  1  encryptor `ready_o`.

## Operation
- **Packer.**
  - Word counter `cnt` runs 0..3.
  - Each accepted word shifts left into the pack register; `cnt` increments.
  - On the accept with `cnt==0`, `mode_i` is latched.
  - On the accept with `cnt==3`, the group is complete and `cnt` wraps to 0.
- **Pack register states:** EMPTY, FILLING, FULL.
  - FULL is entered only when a group completes while the output register is occupied and not draining that cycle.
- **Output register.**
  - Loaded with the complete group, its latched mode and its key when the output register is empty, or when `v_o & ready_i` in the same cycle.
  - The source is the pack register in state FULL. Otherwise it is the group completing in that cycle (bypass of the 4th word).
- **Ready.**
  - `word_ready_o = !FULL & !flush_i`.
  - When FULL drains into the output register, `word_ready_o` returns high on the next cycle.
- **Output handshake.**
  - `v_o` stays high and `content_o`/`key_o`/`encode_or_decode_o` stay stable until `ready_i` is seen.
  - `v_o` falls after the transfer unless a new group loads in the same cycle.
- **Flush.**
  - Clears `cnt` and discards a FILLING group.
  - Does not touch a FULL pack register or the output register.
  - A word presented with `flush_i` high is not accepted.
- **Key without the macro:** `key_i` is sampled in the cycle the group's 4th word is accepted.
- **Arithmetic:** `cnt` is 2 bits (`$clog2(group_size_p/word_width_p)` in general); no other arithmetic.

## Timing
- **Reset values:**
  - `v_o`=0, `content_o`=0, `key_o`=0, `encode_or_decode_o`=0.
  - `cnt`=0, pack register EMPTY.
  - `word_ready_o`=1 (0 while `flush_i`=1).
- **Latency:** 4th word accepted in cycle N → `v_o`=1 in cycle N+1.
- **Throughput:** with `ready_i` held high, one group every 4 cycles, with no bubble on `word_ready_o`.
- **Back-pressure:** with `ready_i` low, one group sits in the output register and one in the pack register. `word_ready_o` drops the cycle after the second group completes.
- **Output transfer and 4th word in the same cycle:** the output reloads from the bypass with no gap; `v_o` stays 1.
- **Reset mid-operation:** all groups, including partial ones, are lost; outputs return to their reset values immediately (asynchronous).

## Configuration
- `SM4_FEEDER_KEY_STREAM_EN` defined:
  - Adds input `word_key_i` (1 bit). Accepted words with `word_key_i=1` go to a separate key packer with its own counter.
  - The key register updates when 4 key words have been collected.
  - `key_o` takes the key register value at group completion. A key update completing in the same cycle as a data group is used by that group.
  - `key_i` is removed. `flush_i` also clears a partial key.
  - Key register reset value is 0.
- Not defined: `word_key_i` is absent, and `key_i` is sampled as described under Operation.

## Structure
- **Package `sm4_encryptor`:**
  - `group_size_p`, `word_width_p`.
  - `words_per_group_lp = group_size_p/word_width_p`.
  - Typedefs `sm4_group_t` and `sm4_word_t`.
  - Enum `feeder_pack_state_e` {EMPTY, FILLING, FULL}.
- **Sub-module `sm4_word_packer`:** counter plus shift register plus completion pulse. Instantiated once for data, and a second time for the key when the macro is enabled.

## Test plan
- Reset, then words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 back-to-back with `ready_i`=1 → next cycle `content_o`=0x0123456789ABCDEFFEDCBA9876543210, `v_o`=1 for one cycle.
- `ready_i`=0, stream 12 words → `word_ready_o` falls after word 8. Raise `ready_i` → groups 1 and 2 come out in order, then word 9 is accepted.
- `mode_i`=1 on word 0 and 0 on words 1–3 → `encode_or_decode_o`=1.
- `flush_i` after 2 words, then 4 new words → `content_o` holds only the new words.
- Assert `reset_i` low while `v_o`=1 → `v_o`, `content_o` and `key_o` go to 0 at once; the next group packs from word 0.
- With `SM4_FEEDER_KEY_STREAM_EN`: 4 key words of 0x0123…3210, then a data group → `key_o`=0x0123456789ABCDEFFEDCBA9876543210.
